// File: rtl/traffic_light_monitor_if.sv
// Controller-to-monitor bundle: sampled light codes in, lamp drives and fault status out.
// TRAFFIC_MON_CLEAR_EN adds the fault_clr request line.
interface traffic_light_monitor_if;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       fault;
  logic [2:0] fault_code;
`ifdef TRAFFIC_MON_CLEAR_EN
  logic       fault_clr;

  modport master (
    output main_light, side_light, fault_clr,
    input  main_lamp, side_lamp, fault, fault_code
  );
  modport slave (
    input  main_light, side_light, fault_clr,
    output main_lamp, side_lamp, fault, fault_code
  );
`else
  modport master (
    output main_light, side_light,
    input  main_lamp, side_lamp, fault, fault_code
  );
  modport slave (
    input  main_light, side_light,
    output main_lamp, side_lamp, fault, fault_code
  );
`endif
endinterface

// File: rtl/traffic_light_monitor.sv
// Traffic-light safety monitor: decodes light codes to lamp drives, latches the first
// violation and flashes red. Define TRAFFIC_MON_CLEAR_EN to allow leaving FAULT via fault_clr.
module traffic_light_monitor #(
  parameter int unsigned MIN_DWELL = 10,
  parameter int unsigned MAX_DWELL = 16,
  parameter int unsigned FLASH_DIV = 8
) (
  input logic                    clk,
  input logic                    rst,
  traffic_light_monitor_if.slave mon
);

  localparam int unsigned CNT_W   = $clog2(MAX_DWELL + 2);
  localparam int unsigned FLASH_W = $clog2(2 * FLASH_DIV);

  localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(MAX_DWELL + 1);
  localparam logic [CNT_W-1:0]   CNT_MIN    = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_DWELL);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(2 * FLASH_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_HALF = FLASH_W'(FLASH_DIV);

  localparam logic [1:0] CODE_R = 2'b00;
  localparam logic [1:0] CODE_Y = 2'b01;
  localparam logic [1:0] CODE_G = 2'b10;
  localparam logic [1:0] CODE_X = 2'b11;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_INVALID  = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_BAD_TRAN = 3'd3;
  localparam logic [2:0] FC_SHORT    = 3'd4;
  localparam logic [2:0] FC_STUCK    = 3'd5;

  typedef enum logic {MONITOR, FAULT} state_e;

  state_e             state_q, state_d;
  logic [1:0]         prev_main_q, prev_main_d;
  logic [1:0]         prev_side_q, prev_side_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic [FLASH_W-1:0] flash_q, flash_d;
  logic [2:0]         main_lamp_q, main_lamp_d;
  logic [2:0]         side_lamp_q, side_lamp_d;
  logic               fault_q, fault_d;
  logic [2:0]         fault_code_q, fault_code_d;

  logic               changed;
  logic [2:0]         viol_code;

  // Unused code 11 decodes to red so a lamp never shows an undefined aspect.
  function automatic logic [2:0] decode(input logic [1:0] code);
    case (code)
      CODE_Y:  decode = LAMP_Y;
      CODE_G:  decode = LAMP_G;
      default: decode = LAMP_R;
    endcase
  endfunction

  function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
    legal_step = (cur == prev) ||
                 (prev == CODE_R && cur == CODE_G) ||
                 (prev == CODE_G && cur == CODE_Y) ||
                 (prev == CODE_Y && cur == CODE_R);
  endfunction

  // Prioritised violation detection against the registered previous pair.
  always_comb begin
    viol_code = FC_NONE;
    changed   = (mon.main_light != prev_main_q) || (mon.side_light != prev_side_q);
    if (mon.main_light == CODE_X || mon.side_light == CODE_X) begin
      viol_code = FC_INVALID;
    end else if (mon.main_light != CODE_R && mon.side_light != CODE_R) begin
      viol_code = FC_CONFLICT;
    end else if (!legal_step(prev_main_q, mon.main_light) ||
                 !legal_step(prev_side_q, mon.side_light)) begin
      viol_code = FC_BAD_TRAN;
    end else if (changed && armed_q && (cnt_q < CNT_MIN)) begin
      viol_code = FC_SHORT;
    end else if (!changed && (cnt_q >= CNT_MAX)) begin
      viol_code = FC_STUCK;
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_main_d  = prev_main_q;
    prev_side_d  = prev_side_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    flash_d      = flash_q;
    main_lamp_d  = main_lamp_q;
    side_lamp_d  = side_lamp_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;

    case (state_q)
      MONITOR: begin
        if (viol_code != FC_NONE) begin
          state_d      = FAULT;
          fault_d      = 1'b1;
          fault_code_d = viol_code;
          flash_d      = '0;
          main_lamp_d  = LAMP_R;
          side_lamp_d  = LAMP_R;
        end else begin
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
          main_lamp_d  = decode(mon.main_light);
          side_lamp_d  = decode(mon.side_light);
          prev_main_d  = mon.main_light;
          prev_side_d  = mon.side_light;
          armed_d      = armed_q | changed;
          if (changed) begin
            cnt_d = CNT_W'(1);
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FAULT: begin
`ifdef TRAFFIC_MON_CLEAR_EN
        if (mon.fault_clr) begin
          // Re-seed history from the live inputs; checking resumes next cycle.
          state_d      = MONITOR;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
          prev_main_d  = mon.main_light;
          prev_side_d  = mon.side_light;
          cnt_d        = CNT_W'(1);
          armed_d      = 1'b0;
          flash_d      = '0;
          main_lamp_d  = decode(mon.main_light);
          side_lamp_d  = decode(mon.side_light);
        end else begin
          flash_d     = (flash_q == FLASH_LAST) ? '0 : flash_q + FLASH_W'(1);
          main_lamp_d = (flash_d < FLASH_HALF) ? LAMP_R : LAMP_OFF;
          side_lamp_d = (flash_d < FLASH_HALF) ? LAMP_R : LAMP_OFF;
        end
`else
        flash_d     = (flash_q == FLASH_LAST) ? '0 : flash_q + FLASH_W'(1);
        main_lamp_d = (flash_d < FLASH_HALF) ? LAMP_R : LAMP_OFF;
        side_lamp_d = (flash_d < FLASH_HALF) ? LAMP_R : LAMP_OFF;
`endif
      end
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MONITOR;
      prev_main_q  <= CODE_R;
      prev_side_q  <= CODE_R;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      flash_q      <= '0;
      main_lamp_q  <= LAMP_R;
      side_lamp_q  <= LAMP_R;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      prev_main_q  <= prev_main_d;
      prev_side_q  <= prev_side_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      flash_q      <= flash_d;
      main_lamp_q  <= main_lamp_d;
      side_lamp_q  <= side_lamp_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign mon.main_lamp  = main_lamp_q;
  assign mon.side_lamp  = side_lamp_q;
  assign mon.fault      = fault_q;
  assign mon.fault_code = fault_code_q;

endmodule
